// File: rtl/vram_scanout_reader.sv
// Read-only VRAM port B client: walks one RGB888 frame, packs R,G,B bytes into pixels,
// buffers them in a small FIFO and presents a valid/ready stream with SOF/EOL sidebands.
module vram_scanout_reader #(
   parameter int unsigned H_RES      = 320,
   parameter int unsigned V_RES      = 240,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_frame_start,
   output logic [17:0] o_vram_addr,
   output logic        o_vram_we,
   input  logic [7:0]  i_vram_q,
   output logic        o_pix_valid,
   input  logic        i_pix_ready,
   output logic [23:0] o_pix_rgb,
   output logic        o_pix_sof,
   output logic        o_pix_eol,
   output logic        o_busy
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned CW1  = CW + 1;
   localparam int unsigned XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW   = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [17:0] BASE = 18'(BASE_ADDR);

   typedef enum logic [2:0] {StIdle, StRdR, StRdG, StRdB, StDone} state_t;
   // Lane of the byte VRAM returns this cycle, i.e. what was issued last cycle
   typedef enum logic [1:0] {TagNone, TagR, TagG, TagB} tag_t;

   state_t          r_state;
   tag_t            r_tag;
   logic [17:0]     r_addr;
   logic            r_busy;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic [7:0]      r_byte_r;
   logic [7:0]      r_byte_g;
   logic            r_sb_sof;
   logic            r_sb_eol;
   logic            r_pending;
   logic [25:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_credit;
   logic            w_push;
   logic            w_pop;
   logic            w_last_x;
   logic            w_last_y;
   logic [25:0]     w_head;

   // A pixel read may only start when its FIFO slot is already guaranteed
   assign w_credit = ({1'b0, r_count} + CW1'(r_pending)) < CW1'(FIFO_DEPTH);
   assign w_push   = (r_tag == TagB);
   assign w_pop    = o_pix_valid && i_pix_ready;
   assign w_last_x = (r_x == XW'(H_RES - 1));
   assign w_last_y = (r_y == YW'(V_RES - 1));
   assign w_head   = r_mem[r_rd_ptr];

   assign o_vram_addr = r_addr;
   assign o_vram_we   = 1'b0;
   assign o_busy      = r_busy;
   assign o_pix_valid = (r_count != '0);
   assign o_pix_rgb   = o_pix_valid ? w_head[23:0] : 24'd0;
   assign o_pix_sof   = o_pix_valid && w_head[25];
   assign o_pix_eol   = o_pix_valid && w_head[24];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_tag     <= TagNone;
         r_addr    <= '0;
         r_busy    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_byte_r  <= '0;
         r_byte_g  <= '0;
         r_sb_sof  <= 1'b0;
         r_sb_eol  <= 1'b0;
         r_pending <= 1'b0;
      end else if (i_frame_start) begin
         r_state   <= StRdR;
         r_tag     <= TagNone;
         r_addr    <= BASE;
         r_busy    <= 1'b1;
         r_x       <= '0;
         r_y       <= '0;
         r_pending <= 1'b0;
      end else begin
         r_tag <= TagNone;
         if (w_push) r_pending <= 1'b0;
         if (r_tag == TagR) r_byte_r <= i_vram_q;
         if (r_tag == TagG) r_byte_g <= i_vram_q;
         case (r_state)
            StRdR: begin
               if (w_credit) begin
                  r_state   <= StRdG;
                  r_addr    <= r_addr + 18'd1;
                  r_tag     <= TagR;
                  r_pending <= 1'b1;
               end
            end
            StRdG: begin
               r_state <= StRdB;
               r_addr  <= r_addr + 18'd1;
               r_tag   <= TagG;
            end
            StRdB: begin
               r_tag    <= TagB;
               r_sb_sof <= (r_x == '0) && (r_y == '0);
               r_sb_eol <= w_last_x;
               if (w_last_x && w_last_y) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= StRdR;
                  r_addr  <= r_addr + 18'd1;
                  if (w_last_x) begin
                     r_x <= '0;
                     r_y <= r_y + YW'(1);
                  end else begin
                     r_x <= r_x + XW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_frame_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_sb_sof, r_sb_eol, r_byte_r, r_byte_g, i_vram_q};
   end

endmodule

// File: tb/tb_vram_scanout_reader.sv
// Directed bench for vram_scanout_reader: VRAM byte i holds i[7:0], so every pixel is
// predictable from its index; a stream monitor checks order, sidebands and counts.
module tb_vram_scanout_reader;

   localparam int H         = 320;
   localparam int V         = 12;
   localparam int N         = H * V;
   localparam int DEPTH     = 8;
   localparam int LAST_ADDR = 3 * N - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_ready = 1'b0;
   logic [7:0]  vram_q = 8'd0;
   logic [17:0] vram_addr;
   logic        vram_we;
   logic        pix_valid;
   logic [23:0] pix_rgb;
   logic        pix_sof;
   logic        pix_eol;
   logic        busy;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          mon_cnt = 0;
   int          sof_cnt = 0;
   int          eol_cnt = 0;
   int          stream_err = 0;
   int          we_bad = 0;
   logic [17:0] max_addr = '0;
   logic [25:0] cap_q [$];

   typedef struct {
      int          idx;
      logic [23:0] rgb;
      logic        sof;
      logic        eol;
   } vec_t;
   vec_t vecs [8];

   always #5 clk = ~clk;

   // VRAM port B: one-cycle registered read, byte i holds i[7:0]
   always @(posedge clk) vram_q <= vram_addr[7:0];

   vram_scanout_reader #(
      .H_RES      (H),
      .V_RES      (V),
      .BASE_ADDR  (0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_frame_start (frame_start),
      .o_vram_addr   (vram_addr),
      .o_vram_we     (vram_we),
      .i_vram_q      (vram_q),
      .o_pix_valid   (pix_valid),
      .i_pix_ready   (pix_ready),
      .o_pix_rgb     (pix_rgb),
      .o_pix_sof     (pix_sof),
      .o_pix_eol     (pix_eol),
      .o_busy        (busy)
   );

   function automatic logic [25:0] model(input int idx);
      logic [31:0] b0, b1, b2;
      b0 = 32'(3 * idx);
      b1 = b0 + 32'd1;
      b2 = b0 + 32'd2;
      return {idx == 0, (idx % H) == H - 1, b0[7:0], b1[7:0], b2[7:0]};
   endfunction

   always @(negedge clk) begin
      if (vram_we !== 1'b0) we_bad++;
      if (vram_addr > max_addr) max_addr = vram_addr;
      if (!rst && pix_valid && pix_ready) begin
         if (mon_cnt >= N || {pix_sof, pix_eol, pix_rgb} !== model(mon_cnt)) stream_err++;
         cap_q.push_back({pix_sof, pix_eol, pix_rgb});
         mon_cnt++;
         if (pix_sof) sof_cnt++;
         if (pix_eol) eol_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_cnt = 0;
      sof_cnt = 0;
      eol_cnt = 0;
      cap_q.delete();
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      mon_clear();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},  32'(vram_addr), 32'd0);
      check({tag, "_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_rgb"},   32'(pix_rgb),   32'd0);
      check({tag, "_sof"},   32'(pix_sof),   32'd0);
      check({tag, "_eol"},   32'(pix_eol),   32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
   endtask

   task automatic wait_frame(input string tag, input int budget, input bit rnd);
      int c;
      c = 0;
      while (!(mon_cnt == N && !busy && !pix_valid) && c < budget) begin
         if (rnd) pix_ready = 1'($urandom_range(0, 1));
         tick();
         c++;
      end
      check({tag, "_complete"}, 32'(c < budget), 32'd1);
   endtask

   task automatic check_cap(input string tag, input int idx, input logic [25:0] exp);
      logic [25:0] got;
      got = (idx < cap_q.size()) ? cap_q[idx] : '1;
      check(tag, 32'(got), 32'(exp));
   endtask

   initial begin
      vecs[0] = '{0,    24'h000102, 1'b1, 1'b0};
      vecs[1] = '{1,    24'h030405, 1'b0, 1'b0};
      vecs[2] = '{85,   24'hFF0001, 1'b0, 1'b0};
      vecs[3] = '{318,  24'hBABBBC, 1'b0, 1'b0};
      vecs[4] = '{319,  24'hBDBEBF, 1'b0, 1'b1};
      vecs[5] = '{320,  24'hC0C1C2, 1'b0, 1'b0};
      vecs[6] = '{639,  24'h7D7E7F, 1'b0, 1'b1};
      vecs[7] = '{3839, 24'hFDFEFF, 1'b0, 1'b1};

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst_held");
      rst = 1'b0;
      tick();
      check_reset_outputs("rst_idle");

      // Full frame, consumer always ready
      pix_ready = 1'b1;
      pulse_fs();
      check("fs_busy", 32'(busy), 32'd1);
      wait_frame("full", 3 * N + 200, 1'b0);
      repeat (20) tick();
      check("full_count", 32'(mon_cnt), 32'(N));
      check("full_busy", 32'(busy), 32'd0);
      check("full_last_addr", 32'(vram_addr), 32'(LAST_ADDR));
      check("full_sof_count", 32'(sof_cnt), 32'd1);
      check("full_eol_count", 32'(eol_cnt), 32'(V));
      check("full_stream_err", 32'(stream_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check_cap($sformatf("vec%0d_pixel", vecs[i].idx), vecs[i].idx,
                   {vecs[i].sof, vecs[i].eol, vecs[i].rgb});
      end

      // Backpressure: FIFO fills, address freezes at the 9th pixel
      pix_ready = 1'b0;
      pulse_fs();
      repeat (60) tick();
      check("bp_addr", 32'(vram_addr), 32'd24);
      check("bp_valid", 32'(pix_valid), 32'd1);
      check("bp_head_rgb", 32'(pix_rgb), 32'h000102);
      check("bp_head_sof", 32'(pix_sof), 32'd1);
      repeat (20) tick();
      check("bp_addr_frozen", 32'(vram_addr), 32'd24);
      check("bp_head_stable", 32'(pix_rgb), 32'h000102);
      check("bp_nothing_taken", 32'(mon_cnt), 32'd0);
      pix_ready = 1'b1;
      repeat (100) tick();
      check_cap("bp_pixel7", 7, {2'b00, 24'h151617});
      check_cap("bp_pixel8", 8, {2'b00, 24'h18191A});
      check("bp_stream_err", 32'(stream_err), 32'd0);

      // Random backpressure over a full frame
      pulse_fs();
      wait_frame("rand", 12 * N, 1'b1);
      pix_ready = 1'b1;
      repeat (20) tick();
      check("rand_count", 32'(mon_cnt), 32'(N));
      check("rand_sof_count", 32'(sof_cnt), 32'd1);
      check("rand_eol_count", 32'(eol_cnt), 32'(V));
      check("rand_stream_err", 32'(stream_err), 32'd0);

      // Restart mid-frame with a non-empty FIFO
      pulse_fs();
      for (int c = 0; c < 5000 && !(mon_cnt >= 1000 && pix_valid); c++) tick();
      check("mid_reached_1000", 32'(mon_cnt >= 1000 && pix_valid), 32'd1);
      pulse_fs();
      check("mid_valid_flushed", 32'(pix_valid), 32'd0);
      check("mid_addr_base", 32'(vram_addr), 32'd0);
      repeat (30) tick();
      check_cap("mid_first", 0, {2'b10, 24'h000102});
      check_cap("mid_second", 1, {2'b00, 24'h030405});
      check("mid_stream_err", 32'(stream_err), 32'd0);

      // Restart in the cycle the B byte of a pixel is returning
      for (int c = 0; c < 100 && !(vram_addr % 3 == 0 && vram_addr > 30 && !pix_valid); c++)
         tick();
      pulse_fs();
      check("midb_valid_flushed", 32'(pix_valid), 32'd0);
      repeat (30) tick();
      check_cap("midb_first", 0, {2'b10, 24'h000102});
      check("midb_stream_err", 32'(stream_err), 32'd0);

      // Reset mid-frame with a stalled consumer; reset beats a concurrent frame start
      pix_ready = 1'b0;
      pulse_fs();
      repeat (40) tick();
      check("rstmid_full", 32'(pix_valid), 32'd1);
      rst = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      check_reset_outputs("rstmid_held");
      rst = 1'b0;
      pix_ready = 1'b1;
      mon_clear();
      repeat (50) tick();
      check_reset_outputs("rstmid_after");
      check("rstmid_no_pixels", 32'(mon_cnt), 32'd0);

      check("vram_we_zero", 32'(we_bad), 32'd0);
      check("addr_bound", 32'(max_addr <= 18'(LAST_ADDR)), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
